// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: register-tag width, the per-stage
// instruction record and the all-zero bubble record.
package hazard_pkg;

  localparam int REG_W = 4;

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             mem_read;
    logic [REG_W-1:0] dst;
  } stage_rec_t;

  localparam stage_rec_t STAGE_BUBBLE = '0;

  // A stage produces register r only if it holds a real, writing instruction.
  function automatic logic rec_hit(stage_rec_t s, logic [REG_W-1:0] r);
    return s.valid & s.wb_en & (s.dst == r);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage record register: async clear, hold when disabled,
// bubble insertion when enabled and bubble_i is set.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       bubble_i,
  input  stage_rec_t rec_i,
  output stage_rec_t rec_o
);

  stage_rec_t rec_q;

  // Capture the upstream record (or a bubble) only while the pipeline advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_q <= STAGE_BUBBLE;
    end else if (en_i) begin
      rec_q <= bubble_i ? STAGE_BUBBLE : rec_i;
    end
  end

  assign rec_o = rec_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks destination tags through EXE/MEM/WB, raises
// stall_id on data hazards and counts stall cycles (saturating).
// Build option HAZARD_FORWARDING_EN: when defined, a forwarding datapath is
// assumed and only load-use hazards stall; when undefined, any in-flight
// producer of a used operand stalls and the MEM/WB write enables read as 0.
module hazard_scoreboard #(
  parameter int REG_W       = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_id,
  input  logic [REG_W-1:0]       src_1,
  input  logic [REG_W-1:0]       src_2,
  input  logic                   two_src,
  input  logic [REG_W-1:0]       dst_id,
  input  logic                   wb_en_id,
  input  logic                   mem_read_id,
  input  logic                   flush,
  input  logic                   mem_ready,
  output logic                   stall_id,
  output logic [REG_W-1:0]       dst_mem,
  output logic [REG_W-1:0]       dst_wb,
  output logic                   wb_en_mem,
  output logic                   wb_en_wb,
  output logic [STALL_CNT_W-1:0] stall_count
);

  import hazard_pkg::*;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  stage_rec_t exe_d, exe_q, mem_q, wb_q;
  logic       load_use, hazard, exe_bubble;
  logic       unused_mem_read;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  // True when stage s writes one of the registers the ID instruction reads.
  function automatic logic use_hit(stage_rec_t s, logic [REG_W-1:0] a,
                                   logic [REG_W-1:0] b, logic two);
    return rec_hit(s, a) | (two & rec_hit(s, b));
  endfunction

  assign exe_d = '{valid: 1'b1, wb_en: wb_en_id, mem_read: mem_read_id, dst: dst_id};

  hazard_stage_reg u_exe (
    .clk      (clk),
    .rst      (rst),
    .en_i     (mem_ready),
    .bubble_i (exe_bubble),
    .rec_i    (exe_d),
    .rec_o    (exe_q)
  );

  hazard_stage_reg u_mem (
    .clk      (clk),
    .rst      (rst),
    .en_i     (mem_ready),
    .bubble_i (1'b0),
    .rec_i    (exe_q),
    .rec_o    (mem_q)
  );

  hazard_stage_reg u_wb (
    .clk      (clk),
    .rst      (rst),
    .en_i     (mem_ready),
    .bubble_i (1'b0),
    .rec_i    (mem_q),
    .rec_o    (wb_q)
  );

  // Load result is not available until after MEM, so a dependent ID
  // instruction must wait one cycle even with forwarding.
  assign load_use = valid_id & exe_q.mem_read & use_hit(exe_q, src_1, src_2, two_src);

`ifdef HAZARD_FORWARDING_EN
  assign hazard    = load_use;
  assign wb_en_mem = mem_q.valid & mem_q.wb_en;
  assign wb_en_wb  = wb_q.valid & wb_q.wb_en;
`else
  // Without forwarding every in-flight producer blocks its consumer.
  assign hazard    = valid_id & (use_hit(exe_q, src_1, src_2, two_src) |
                                 use_hit(mem_q, src_1, src_2, two_src) |
                                 use_hit(wb_q,  src_1, src_2, two_src));
  assign wb_en_mem = 1'b0;
  assign wb_en_wb  = 1'b0;
`endif

  // Reset masks the stall immediately; memory wait overrides flush.
  assign stall_id   = ~rst & (~mem_ready | (hazard & ~flush));
  assign exe_bubble = flush | hazard | ~valid_id;

  assign dst_mem = mem_q.dst;
  assign dst_wb  = wb_q.dst;

  // MEM/WB mem_read bits only travel along; nothing downstream needs them here.
  assign unused_mem_read = mem_q.mem_read ^ wb_q.mem_read;

  // Saturating stall counter next state.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_id && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
